// File: rtl/tpu_run_sequencer_if.sv
// Job-control and datapath-sequencing signals between a job issuer (master)
// and the TPU run sequencer (slave).
interface tpu_run_sequencer_if #(
    parameter int ADDRESSSIZE = 10,
    parameter int WSEL_BW     = 2
);
    logic                   start;
    logic                   abort;
    logic [ADDRESSSIZE-1:0] ub_base_addr;
    logic [ADDRESSSIZE-1:0] res_base_addr;
    logic [ADDRESSSIZE:0]   num_vectors;
    logic [WSEL_BW-1:0]     weight_sel;

    logic                   busy;
    logic [WSEL_BW-1:0]     wsram_addr;
    logic                   we_rl;
    logic [ADDRESSSIZE-1:0] ub_rd_addr;
    logic                   ub_rd_valid;
    logic                   res_we;
    logic [ADDRESSSIZE-1:0] res_addr;
    logic                   done;
    logic                   aborted;

    // start is a level request: it is taken only while the sequencer is idle
    // (busy=0) and ignored otherwise; there is no ready/ack beyond busy.
    modport master (
        output start, abort, ub_base_addr, res_base_addr, num_vectors, weight_sel,
        input  busy, wsram_addr, we_rl, ub_rd_addr, ub_rd_valid, res_we, res_addr,
               done, aborted
    );

    modport slave (
        input  start, abort, ub_base_addr, res_base_addr, num_vectors, weight_sel,
        output busy, wsram_addr, we_rl, ub_rd_addr, ub_rd_valid, res_we, res_addr,
               done, aborted
    );
endinterface

// File: rtl/tpu_run_sequencer.sv
// Single-job TPU sequencer: weight tile select/reload, UB row streaming,
// result SRAM write-back after a fixed pipeline latency, then done.
module tpu_run_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WSEL_BW     = 2,
    parameter int RES_LAT     = 194,
    parameter int CNT_BW      = 12
) (
    input  logic                clk,
    input  logic                rst,
    tpu_run_sequencer_if.slave  bus,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {IDLE, W_ADDR, W_LOAD, RUN, DONE} state_t;

    localparam logic [CNT_BW-1:0] RES_LAT_C = CNT_BW'(RES_LAT);

    state_t                 state_q, state_d;
    logic [CNT_BW-1:0]      cyc_q, cyc_d, next_cyc, num_ext, last_cyc;
    logic [ADDRESSSIZE-1:0] ub_base_q, res_base_q, res_off;
    logic [ADDRESSSIZE:0]   num_q;
    logic                   load_job, run_next;

    logic                   busy_q, busy_d;
    logic [WSEL_BW-1:0]     wsram_q, wsram_d;
    logic                   we_rl_q, we_rl_d;
    logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
    logic                   ub_valid_q, ub_valid_d;
    logic                   res_we_q, res_we_d;
    logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    assign num_ext  = CNT_BW'(num_q);
    // DONE occupies the slot of cyc == RES_LAT+num, so RUN ends one count earlier.
    assign last_cyc = RES_LAT_C + num_ext - CNT_BW'(1);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        next_cyc  = cyc_q;
        load_job  = 1'b0;
        run_next  = 1'b0;
        wsram_d   = wsram_q;
        we_rl_d   = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = W_ADDR;
                    load_job = 1'b1;
                    wsram_d  = bus.weight_sel;
                end
            end
            W_ADDR: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = W_LOAD;
                    we_rl_d = 1'b1;
                end
            end
            W_LOAD: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d  = RUN;
                    next_cyc = '0;
                    cyc_d    = '0;
                    run_next = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cyc_q == last_cyc) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    next_cyc = cyc_q + CNT_BW'(1);
                    cyc_d    = next_cyc;
                    run_next = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the cycle being entered, then registered.
    always_comb begin
        busy_d     = (state_d != IDLE);
        res_off    = next_cyc[ADDRESSSIZE-1:0] - RES_LAT_C[ADDRESSSIZE-1:0];
        ub_valid_d = run_next && (next_cyc < num_ext);
        ub_addr_d  = ub_valid_d ? ub_base_q + next_cyc[ADDRESSSIZE-1:0] : ub_addr_q;
        res_we_d   = run_next && (next_cyc >= RES_LAT_C) && (next_cyc < RES_LAT_C + num_ext);
        res_addr_d = res_we_d ? res_base_q + res_off : res_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            ub_base_q  <= '0;
            res_base_q <= '0;
            num_q      <= '0;
            busy_q     <= 1'b0;
            wsram_q    <= '0;
            we_rl_q    <= 1'b0;
            ub_addr_q  <= '0;
            ub_valid_q <= 1'b0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            if (load_job) begin
                ub_base_q  <= bus.ub_base_addr;
                res_base_q <= bus.res_base_addr;
                num_q      <= bus.num_vectors;
            end
            busy_q     <= busy_d;
            wsram_q    <= wsram_d;
            we_rl_q    <= we_rl_d;
            ub_addr_q  <= ub_addr_d;
            ub_valid_q <= ub_valid_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wsram_addr  = wsram_q;
    assign bus.we_rl       = we_rl_q;
    assign bus.ub_rd_addr  = ub_addr_q;
    assign bus.ub_rd_valid = ub_valid_q;
    assign bus.res_we      = res_we_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Scoreboard bench for tpu_run_sequencer: directed jobs push timed expectations,
// a negedge monitor pops and compares every DUT event.
module tb_tpu_run_sequencer;
    localparam int A       = 10;
    localparam int WS      = 2;
    localparam int RES_LAT = 194;
    localparam int CNT_BW  = 12;
    localparam int EW      = 32 + A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    logic [31:0] cycle_cnt = '0;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_ub_q[$];
    logic [EW-1:0] exp_res_q[$];
    logic [31:0]   exp_done_q[$];
    logic [31:0]   exp_abort_q[$];
    logic [WS-1:0] exp_wsel_q[$];

    tpu_run_sequencer_if #(.ADDRESSSIZE(A), .WSEL_BW(WS)) bus ();

    tpu_run_sequencer #(
        .ADDRESSSIZE(A), .WSEL_BW(WS), .RES_LAT(RES_LAT), .CNT_BW(CNT_BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event value 0x%0h at cycle %0d, nothing expected", name, act, cycle_cnt);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ub_rd_valid) begin
                if (exp_ub_q.size() == 0) unexpected("ub_rd", 64'(bus.ub_rd_addr));
                else check("ub_rd {cycle,addr}", 64'({cycle_cnt, bus.ub_rd_addr}), 64'(exp_ub_q.pop_front()));
            end
            if (bus.res_we) begin
                if (exp_res_q.size() == 0) unexpected("res_we", 64'(bus.res_addr));
                else check("res_we {cycle,addr}", 64'({cycle_cnt, bus.res_addr}), 64'(exp_res_q.pop_front()));
            end
            if (bus.we_rl) begin
                if (exp_wsel_q.size() == 0) unexpected("we_rl", 64'(bus.wsram_addr));
                else check("we_rl wsram_addr", 64'(bus.wsram_addr), 64'(exp_wsel_q.pop_front()));
            end
            if (bus.done) begin
                check("done/aborted exclusive", 64'(bus.aborted), 64'd0);
                if (exp_done_q.size() == 0) unexpected("done", 64'(cycle_cnt));
                else check("done cycle", 64'(cycle_cnt), 64'(exp_done_q.pop_front()));
            end
            if (bus.aborted) begin
                if (exp_abort_q.size() == 0) unexpected("aborted", 64'(cycle_cnt));
                else check("aborted cycle", 64'(cycle_cnt), 64'(exp_abort_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_job(input logic [A-1:0] ub_base, input logic [A-1:0] res_base,
                           input logic [A:0] num, input logic [WS-1:0] wsel);
        bus.ub_base_addr  = ub_base;
        bus.res_base_addr = res_base;
        bus.num_vectors   = num;
        bus.weight_sel    = wsel;
    endtask

    task automatic issue(input logic [A-1:0] ub_base, input logic [A-1:0] res_base,
                         input logic [A:0] num, input logic [WS-1:0] wsel,
                         output logic [31:0] t);
        @(negedge clk);
        set_job(ub_base, res_base, num, wsel);
        bus.start = 1'b1;
        t = cycle_cnt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Model: UB row k at t+3+k, result row k at t+3+RES_LAT+k, done at t+3+RES_LAT+num.
    task automatic push_job(input logic [31:0] t, input logic [A-1:0] ub_base,
                            input logic [A-1:0] res_base, input int num, input logic [WS-1:0] wsel);
        logic [31:0]  tc;
        logic [A-1:0] ad;
        for (int i = 0; i < num; i++) begin
            tc = t + 32'(3 + i);
            ad = ub_base + A'(i);
            exp_ub_q.push_back({tc, ad});
            tc = t + 32'(3 + RES_LAT + i);
            ad = res_base + A'(i);
            exp_res_q.push_back({tc, ad});
        end
        exp_done_q.push_back(t + 32'(3 + RES_LAT + num));
        exp_wsel_q.push_back(wsel);
    endtask

    task automatic wait_jobs(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_done_q.size() == 0 && exp_abort_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, busy=%0b done_q=%0d abort_q=%0d",
                     name, budget, bus.busy, exp_done_q.size(), exp_abort_q.size());
        end
        @(negedge clk);
        check({name, " ub left"},  64'(exp_ub_q.size()),   64'd0);
        check({name, " res left"}, 64'(exp_res_q.size()),  64'd0);
        check({name, " wsel left"}, 64'(exp_wsel_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " busy"},        64'(bus.busy),        64'd0);
        check({name, " we_rl"},       64'(bus.we_rl),       64'd0);
        check({name, " ub_rd_valid"}, 64'(bus.ub_rd_valid), 64'd0);
        check({name, " res_we"},      64'(bus.res_we),      64'd0);
        check({name, " done"},        64'(bus.done),        64'd0);
        check({name, " aborted"},     64'(bus.aborted),     64'd0);
        check({name, " wsram_addr"},  64'(bus.wsram_addr),  64'd0);
        check({name, " ub_rd_addr"},  64'(bus.ub_rd_addr),  64'd0);
        check({name, " res_addr"},    64'(bus.res_addr),    64'd0);
        check({name, " state"},       64'(dbg_state),       64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0]  t, t2;
        logic [A-1:0] ad;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_job('0, '0, '0, '0);

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // basic job
        issue(10'h010, 10'h000, 11'd4, 2'd2, t);
        for (int i = 0; i < 4; i++) begin
            ad = 10'h010 + A'(i);
            exp_ub_q.push_back({t + 32'(3 + i), ad});
            ad = A'(i);
            exp_res_q.push_back({t + 32'(197 + i), ad});
        end
        exp_done_q.push_back(t + 32'd201);
        exp_wsel_q.push_back(2'd2);
        wait_jobs("basic", 260);
        check("basic wsram_addr holds", 64'(bus.wsram_addr), 64'd2);

        // address wrap
        issue(10'h3FE, 10'h3FF, 11'd3, 2'd1, t);
        exp_ub_q.push_back({t + 32'd3, 10'h3FE});
        exp_ub_q.push_back({t + 32'd4, 10'h3FF});
        exp_ub_q.push_back({t + 32'd5, 10'h000});
        exp_res_q.push_back({t + 32'd197, 10'h3FF});
        exp_res_q.push_back({t + 32'd198, 10'h000});
        exp_res_q.push_back({t + 32'd199, 10'h001});
        exp_done_q.push_back(t + 32'd200);
        exp_wsel_q.push_back(2'd1);
        wait_jobs("wrap", 260);
        check("wrap ub_rd_addr holds", 64'(bus.ub_rd_addr), 64'h000);
        check("wrap res_addr holds",   64'(bus.res_addr),   64'h001);

        // empty job
        issue(10'h055, 10'h066, 11'd0, 2'd3, t);
        exp_done_q.push_back(t + 32'd197);
        exp_wsel_q.push_back(2'd3);
        wait_jobs("num0", 260);

        // abort at cyc=100, then a fresh job
        issue(10'h080, 10'h200, 11'd64, 2'd1, t);
        for (int i = 0; i < 64; i++) begin
            ad = 10'h080 + A'(i);
            exp_ub_q.push_back({t + 32'(3 + i), ad});
        end
        exp_wsel_q.push_back(2'd1);
        exp_abort_q.push_back(t + 32'd104);
        while (cycle_cnt < t + 32'd103) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort busy next", 64'(bus.busy), 64'd0);
        check("abort state next", 64'(dbg_state), 64'd0);
        wait_jobs("abort", 40);
        issue(10'h123, 10'h321, 11'd5, 2'd0, t);
        push_job(t, 10'h123, 10'h321, 5, 2'd0);
        wait_jobs("after_abort", 260);

        // reset mid-RUN: no done, everything cleared
        issue(10'h100, 10'h040, 11'd8, 2'd3, t);
        for (int i = 0; i < 8; i++) begin
            ad = 10'h100 + A'(i);
            exp_ub_q.push_back({t + 32'(3 + i), ad});
        end
        exp_wsel_q.push_back(2'd3);
        while (cycle_cnt < t + 32'd53) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (250) @(negedge clk);
        check("mid_reset busy stays 0", 64'(bus.busy), 64'd0);
        wait_jobs("mid_reset", 10);

        // start held high: one job, next one only from IDLE with latched new inputs
        @(negedge clk);
        set_job(10'h200, 10'h300, 11'd2, 2'd2);
        bus.start = 1'b1;
        t = cycle_cnt;
        push_job(t, 10'h200, 10'h300, 2, 2'd2);
        t2 = t + 32'd200;
        push_job(t2, 10'h2F0, 10'h0F0, 3, 2'd1);
        repeat (10) @(negedge clk);
        set_job(10'h2F0, 10'h0F0, 11'd3, 2'd1);
        while (cycle_cnt < t2 + 32'd2) @(negedge clk);
        bus.start = 1'b0;
        wait_jobs("start_held", 260);
        check("final done_q empty",  64'(exp_done_q.size()),  64'd0);
        check("final abort_q empty", 64'(exp_abort_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
